// File: rtl/npu_pkg.sv
// Shared NPU types: default pixel width, pixel type and the feature-map streamer states.
package npu_pkg;

  localparam int NPU_DATA_W = 22;

  typedef logic signed [NPU_DATA_W-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    GAP,
    DRAIN,
    DONE
  } stream_state_t;

endpackage

// File: rtl/fmap_streamer_raster_counter.sv
// Raster-order (y outer, x inner) position counter with row/frame-end flags and linear address.
module raster_counter #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  output logic [$clog2(WIDTH)-1:0]  cnt_x,
  output logic [$clog2(HEIGHT)-1:0] cnt_y,
  output logic                      last_in_row,
  output logic                      last_in_frame,
  output logic [ADDR_W-1:0]         addr
);

  localparam int X_W = $clog2(WIDTH);
  localparam int Y_W = $clog2(HEIGHT);

  assign last_in_row   = (cnt_x == X_W'(WIDTH - 1));
  assign last_in_frame = last_in_row && (cnt_y == Y_W'(HEIGHT - 1));
  assign addr          = ADDR_W'(cnt_y) * ADDR_W'(WIDTH) + ADDR_W'(cnt_x);

  // The frame-end step wraps both counters, so the next frame starts at the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (clr) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (en) begin
      if (last_in_row) begin
        cnt_x <= '0;
        cnt_y <= last_in_frame ? '0 : cnt_y + 1'b1;
      end else begin
        cnt_x <= cnt_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_streamer.sv
// Streams a stored feature map from RAM into the Max_Pooling pixel input.
// Optional inter-row idle gap: define FMAP_STREAMER_ROW_GAP_EN.
module fmap_streamer
  import npu_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int DATA_W     = NPU_DATA_W,
  parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int ROW_GAP    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     pause,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     start_signal,
  output logic                     pixel_valid,
  output logic signed [DATA_W-1:0] pixel_in,
  output logic                     done_signal,
  output logic                     busy
);

  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);

  if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0 || IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0 ||
      ROW_GAP < 1) begin : g_bad_params
    $error("fmap_streamer: frame dimensions must be even and >= 2, ROW_GAP >= 1");
  end

  stream_state_t state_q, state_d;

  logic           cnt_clr;
  logic [X_W-1:0] cnt_x;
  logic [Y_W-1:0] cnt_y;
  logic           last_in_row;
  logic           last_in_frame;
  logic           unused_raster;

  assign unused_raster = ^{cnt_x, cnt_y, last_in_row};

  raster_counter #(
    .WIDTH (IMG_WIDTH),
    .HEIGHT(IMG_HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_raster (
    .clk          (clk),
    .rst          (rst),
    .clr          (cnt_clr),
    .en           (mem_rd_en),
    .cnt_x        (cnt_x),
    .cnt_y        (cnt_y),
    .last_in_row  (last_in_row),
    .last_in_frame(last_in_frame),
    .addr         (mem_rd_addr)
  );

`ifdef FMAP_STREAMER_ROW_GAP_EN
  localparam int GAP_W = $clog2(ROW_GAP + 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             gap_last;

  assign gap_last = (gap_cnt == GAP_W'(ROW_GAP - 1));

  // Only unpaused cycles count towards the gap, so pause stretches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (state_q != GAP) begin
      gap_cnt <= '0;
    end else if (!pause) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_signal = 1'b0;
    done_signal  = 1'b0;
    mem_rd_en    = 1'b0;
    cnt_clr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = START;
      end
      START: begin
        start_signal = 1'b1;
        cnt_clr      = 1'b1;
        state_d      = READ;
      end
      READ: begin
        if (!pause) begin
          mem_rd_en = 1'b1;
          if (last_in_frame) begin
            state_d = DRAIN;
          end
`ifdef FMAP_STREAMER_ROW_GAP_EN
          else if (last_in_row) begin
            state_d = GAP;
          end
`endif
        end
      end
`ifdef FMAP_STREAMER_ROW_GAP_EN
      GAP: begin
        if (!pause && gap_last) state_d = READ;
      end
`endif
      DRAIN: state_d = DONE;
      DONE: begin
        done_signal = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Read pipe stage p1: RAM data lands one cycle after the strobe.
  logic                     vld_p1;
  logic signed [DATA_W-1:0] pix_hold_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1      <= 1'b0;
      pix_hold_p1 <= '0;
    end else begin
      vld_p1 <= mem_rd_en;
      if (vld_p1) pix_hold_p1 <= mem_rd_data;
    end
  end

  assign pixel_valid = vld_p1;
  assign pixel_in    = vld_p1 ? mem_rd_data : pix_hold_p1;

endmodule

// File: tb/tb_fmap_streamer.sv
// Randomized self-checking bench for fmap_streamer on a 4x4 frame with a RAM model.
module tb_fmap_streamer;
  import npu_pkg::*;

  localparam int W       = 4;
  localparam int H       = 4;
  localparam int NPIX    = W * H;
  localparam int DW      = 22;
  localparam int AW      = 4;
  localparam int ROW_GAP = 2;
  localparam int MAXR    = 200;
`ifdef FMAP_STREAMER_ROW_GAP_EN
  localparam int GAP = ROW_GAP;
`else
  localparam int GAP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              go = 1'b0;
  logic              pause = 1'b0;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  pixel_t            mem_rd_data = '0;
  logic              start_signal;
  logic              pixel_valid;
  pixel_t            pixel_in;
  logic              done_signal;
  logic              busy;

  fmap_streamer #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .ROW_GAP   (ROW_GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .pause       (pause),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .start_signal(start_signal),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .done_signal (done_signal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  pixel_t ram [NPIX];
  int     checks = 0;
  int     failures = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  pixel_t got_v[$];
  int     got_t[$];
  int     start_cnt = 0;
  int     done_cnt = 0;
  int     done_t = -1;
  int     dv_cnt = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      got_v.push_back(pixel_in);
      got_t.push_back(cyc);
    end
    if (start_signal) start_cnt++;
    if (done_signal) begin
      done_cnt++;
      done_t = cyc;
      if (pixel_valid) dv_cnt++;
    end
  end

  bit   pz [MAXR];
  int   exp_t [NPIX];
  int   exp_done;
  int   frame_s;
  int   go_cyc;
  bit   timed_out;
  logic busy_at_start;
  logic busy_after;

  task automatic fill_ram(input bit ramp);
    for (int a = 0; a < NPIX; a++) ram[a] = ramp ? pixel_t'(a + 1) : pixel_t'($urandom());
  endtask

  // Frame timing from the rules: reads start the cycle after start_signal, one per
  // unpaused cycle, each pixel shows up one cycle after its read, row gaps count unpaused cycles.
  task automatic build_model(input int s);
    int r, issued, gapleft;
    r = 1; issued = 0; gapleft = 0;
    while (issued < NPIX && r < MAXR) begin
      if (!pz[r]) begin
        if (gapleft > 0) gapleft--;
        else begin
          exp_t[issued] = s + r + 1;
          issued++;
          if ((issued % W) == 0 && issued < NPIX) gapleft = GAP;
        end
      end
      r++;
    end
    exp_done = exp_t[NPIX-1] + 1;
  endtask

  // mode: 0 no pause, 1 pause 3 cycles right after pixel 5 is read, 2 random pause.
  task automatic run_frame(input int mode, input int go_r);
    int budget;
    got_v.delete(); got_t.delete();
    start_cnt = 0; done_cnt = 0; done_t = -1; dv_cnt = 0;
    for (int r = 0; r < MAXR; r++)
      pz[r] = (mode == 2) ? ($urandom_range(0, 3) == 0) : (mode == 1 && r >= 6 && r <= 8);
    @(posedge clk); #1;
    go = 1'b1; go_cyc = cyc;
    @(posedge clk); #1;
    go = 1'b0;
    frame_s = -1; budget = 0; busy_at_start = 1'b0;
    while (done_cnt == 0 && budget < MAXR - 1) begin
      if (frame_s < 0 && start_signal) begin
        frame_s = cyc;
        busy_at_start = busy;
      end
      pause = (frame_s >= 0) ? pz[cyc - frame_s] : 1'b0;
      go    = (frame_s >= 0 && go_r > 0 && (cyc - frame_s) == go_r);
      @(posedge clk); #1;
      budget++;
    end
    pause = 1'b0; go = 1'b0;
    busy_after = busy;
    timed_out = (done_cnt == 0);
    build_model(frame_s < 0 ? 0 : frame_s);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({start_signal, pixel_valid, done_signal, busy, mem_rd_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {start_signal, pixel_valid, done_signal, busy, mem_rd_en});
    end
    checks++;
    if (pixel_in !== '0) begin
      failures++; $display("FAIL reset_pixel got=%0d want=0", pixel_in);
    end
    checks++;
    if (mem_rd_addr !== '0) begin
      failures++; $display("FAIL reset_addr got=%0d want=0", mem_rd_addr);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_stream_basic;
    fill_ram(1'b1);
    run_frame(0, 0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++;
    if (frame_s != go_cyc + 1) begin
      failures++; $display("FAIL basic_start_lat got=%0d want=%0d", frame_s, go_cyc + 1);
    end
    checks++;
    if (start_cnt != 1 || busy_at_start !== 1'b1) begin
      failures++; $display("FAIL basic_start got=%0d/%b want=1/1", start_cnt, busy_at_start);
    end
    checks++;
    if (got_v.size() != NPIX) begin
      failures++; $display("FAIL basic_count got=%0d want=%0d", got_v.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < got_v.size(); i++) begin
      checks++;
      if (got_v[i] !== ram[i] || got_t[i] != exp_t[i]) begin
        failures++;
        $display("FAIL basic_pix%0d got=%0d@%0d want=%0d@%0d", i, got_v[i], got_t[i], ram[i], exp_t[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_t != exp_done || dv_cnt != 0) begin
      failures++;
      $display("FAIL basic_done got=%0d@%0d dv=%0d want=1@%0d dv=0", done_cnt, done_t, dv_cnt, exp_done);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      failures++; $display("FAIL basic_busy_drop got=%b want=0", busy_after);
    end
  endtask

  task automatic test_pause(input int mode, input int frames);
    for (int f = 0; f < frames; f++) begin
      fill_ram(1'b0);
      run_frame(mode, 0);
      checks++;
      if (timed_out || got_v.size() != NPIX) begin
        failures++;
        $display("FAIL pause_m%0d_count got=%0d timeout=%0d want=%0d", mode, got_v.size(), timed_out, NPIX);
      end
      for (int i = 0; i < NPIX && i < got_v.size(); i++) begin
        checks++;
        if (got_v[i] !== ram[i] || got_t[i] != exp_t[i]) begin
          failures++;
          $display("FAIL pause_m%0d_pix%0d got=%0d@%0d want=%0d@%0d",
                   mode, i, got_v[i], got_t[i], ram[i], exp_t[i]);
        end
      end
      checks++;
      if (done_cnt != 1 || done_t != exp_done) begin
        failures++;
        $display("FAIL pause_m%0d_done got=%0d@%0d want=1@%0d", mode, done_cnt, done_t, exp_done);
      end
    end
  endtask

  task automatic test_go_while_busy;
    fill_ram(1'b0);
    run_frame(0, 9);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (start_cnt != 1 || done_cnt != 1 || got_v.size() != NPIX) begin
      failures++;
      $display("FAIL gobusy_frame got=start%0d done%0d pix%0d want=start1 done1 pix%0d",
               start_cnt, done_cnt, got_v.size(), NPIX);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL gobusy_queued got=busy%b want=0", busy);
    end
    fill_ram(1'b0);
    run_frame(0, 0);
    checks++;
    if (done_cnt != 1 || got_v.size() != NPIX) begin
      failures++; $display("FAIL gobusy_second got=%0d/%0d want=1/%0d", done_cnt, got_v.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < got_v.size(); i++) begin
      checks++;
      if (got_v[i] !== ram[i]) begin
        failures++; $display("FAIL gobusy_pix%0d got=%0d want=%0d", i, got_v[i], ram[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    fill_ram(1'b1);
    done_cnt = 0;
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      if (pixel_valid && pixel_in == pixel_t'(10)) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rstmid_reach got=no_pixel10 want=pixel10"); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({start_signal, pixel_valid, done_signal, busy, mem_rd_en} !== 5'b0 || pixel_in !== '0) begin
      failures++;
      $display("FAIL rstmid_async got=%b/%0d want=00000/0",
               {start_signal, pixel_valid, done_signal, busy, mem_rd_en}, pixel_in);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 0) begin
      failures++; $display("FAIL rstmid_no_done got=%0d want=0", done_cnt);
    end
    run_frame(0, 0);
    checks++;
    if (done_cnt != 1 || got_v.size() != NPIX) begin
      failures++; $display("FAIL rstmid_refill got=%0d/%0d want=1/%0d", done_cnt, got_v.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < got_v.size(); i++) begin
      checks++;
      if (got_v[i] !== pixel_t'(i + 1)) begin
        failures++; $display("FAIL rstmid_pix%0d got=%0d want=%0d", i, got_v[i], i + 1);
      end
    end
  endtask

  task automatic test_pooling;
    int     pool_exp [4];
    pixel_t m;
    pool_exp = '{6, 8, 14, 16};
    fill_ram(1'b1);
    run_frame(2, 0);
    checks++;
    if (got_v.size() != NPIX) begin
      failures++; $display("FAIL pool_count got=%0d want=%0d", got_v.size(), NPIX);
    end else begin
      for (int b = 0; b < 4; b++) begin
        m = got_v[(b / 2) * 2 * W + (b % 2) * 2];
        for (int d = 0; d < 4; d++)
          if (got_v[((b / 2) * 2 + d / 2) * W + (b % 2) * 2 + d % 2] > m)
            m = got_v[((b / 2) * 2 + d / 2) * W + (b % 2) * 2 + d % 2];
        checks++;
        if (m != pixel_t'(pool_exp[b])) begin
          failures++; $display("FAIL pool_out%0d got=%0d want=%0d", b, m, pool_exp[b]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_pause(1, 1);
    test_pause(2, 4);
    test_go_while_busy();
    test_reset_mid();
    test_pooling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
